// File: rtl/out_port_display_pkg.sv
// Shared definitions for the output-port display block: FSM state
// encoding, hex-to-7-segment table (active-high gfedcba) and the blank
// pattern driven onto the active-low segment lines.
package out_port_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // nothing shown yet (or after reset): display blank
    ST_HOLD = 2'd1,  // current word still inside its minimum display time
    ST_WAIT = 2'd2   // minimum time served, no new word: keep last word
  } disp_state_t;

  // Active-low segment value for a dark digit.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-high {g,f,e,d,c,b,a}, indexed by nibble value (entry 15 first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Active-low segment pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
    return ~HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/out_port_display_if.sv
// CPU output-port write bus: one-cycle write strobe plus the word split
// into MSB/LSB bytes.
// master: CPU side (drives everything); slave: display side (samples).
interface out_port_display_if;
  logic       OUT_MW;      // each high cycle carries one word
  logic [7:0] OUTPUT_LSB;  // word bits [7:0]
  logic [7:0] OUTPUT_MSB;  // word bits [15:8]

  modport master (output OUT_MW, output OUTPUT_LSB, output OUTPUT_MSB);
  modport slave  (input  OUT_MW, input  OUTPUT_LSB, input  OUTPUT_MSB);
endinterface

// File: rtl/out_word_fifo.sv
// Purpose: small synchronous show-ahead FIFO for captured output words.
// Latency: a pushed word is visible on dout the edge after it is written.
// Backpressure: push is ignored when full unless a pop happens on the same edge.
// Ports: clk, rst_n (async active-low), push/din, pop, dout (head), full, empty.
module out_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign rd_en = pop && !empty;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign wr_en = push && (!full || rd_en);

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/out_port_display.sv
// Purpose: buffer CPU output-port words and show each on a 4-digit muxed 7-seg display.
// Latency: word written into an empty FIFO while idle/waiting reaches shown_word next edge.
// Backpressure: none to the CPU; a word arriving with the FIFO full (and no pop) is dropped, overflow sticks.
// Ports: main_clk, rst (async active-low), bus (write strobe + word), shown_word,
//        word_valid, fifo_full, overflow, an_n (digit enables), seg_n (gfedcba), all active-low display lines.
module out_port_display
  import out_port_display_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int SCAN_DIV    = 16
) (
  input  logic                main_clk,
  input  logic                rst,
  out_port_display_if.slave   bus,
  output logic [15:0]         shown_word,
  output logic                word_valid,
  output logic                fifo_full,
  output logic                overflow,
  output logic [3:0]          an_n,
  output logic [6:0]          seg_n
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  disp_state_t   state;
  disp_state_t   state_nxt;
  logic [HW-1:0] hold_cnt;
  logic          pop;
  logic [15:0]   fifo_head;
  logic          fifo_empty;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    nibble;

  out_word_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (main_clk),
    .rst_n (rst),
    .push  (bus.OUT_MW),
    .pop   (pop),
    .din   ({bus.OUTPUT_MSB, bus.OUTPUT_LSB}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state / pop decision. Every pop is also a display load.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE, ST_WAIT: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge main_clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      shown_word <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        shown_word <= fifo_head;
        word_valid <= 1'b1;
        // Loading N-1 and expiring on zero gives exactly HOLD_CYCLES cycles.
        hold_cnt   <= HOLD_LOAD;
      end else if (state == ST_HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
      if (bus.OUT_MW && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Free-running digit scan; keeps counting while the display is blank.
  always_ff @(posedge main_clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  assign nibble = shown_word[{digit_idx, 2'b00} +: 4];

  // Registered display drive: reflects digit/word/state one cycle late.
  always_ff @(posedge main_clk or negedge rst) begin
    if (!rst) begin
      an_n  <= 4'b1111;
      seg_n <= SEG_BLANK;
    end else if (state == ST_IDLE) begin
      an_n  <= 4'b1111;
      seg_n <= SEG_BLANK;
    end else begin
      an_n  <= ~(4'b0001 << digit_idx);
      seg_n <= hex_to_seg_n(nibble);
    end
  end

endmodule

// File: tb/tb_out_port_display.sv
// Bench for out_port_display with short hold/scan settings. A queue-based
// reference model, driven by edge counts since reset, predicts every output
// each cycle; directed scenarios add constant checks on top.
module tb_out_port_display;

  localparam int DEPTH = 4;
  localparam int HOLD  = 8;
  localparam int SDIV  = 2;

  // Active-high gfedcba per hex digit, written out independently here.
  localparam logic [6:0] HEX_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        main_clk = 1'b0;
  logic        rst      = 1'b0;
  logic [15:0] shown_word;
  logic        word_valid;
  logic        fifo_full;
  logic        overflow;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  out_port_display_if bus_if ();

  out_port_display #(
    .FIFO_DEPTH  (DEPTH),
    .HOLD_CYCLES (HOLD),
    .SCAN_DIV    (SDIV)
  ) dut (
    .main_clk   (main_clk),
    .rst        (rst),
    .bus        (bus_if),
    .shown_word (shown_word),
    .word_valid (word_valid),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .an_n       (an_n),
    .seg_n      (seg_n)
  );

  always #5 main_clk = ~main_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_q [$];
  int          m_mode;   // 0 blank, 1 holding, 2 waiting on last word
  int          m_edges;  // edges since reset release
  int          m_load;   // edge number of the latest load
  logic [15:0] m_shown;
  logic        m_valid;
  logic        m_ovf;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  task automatic model_reset();
    m_q.delete();
    m_mode = 0; m_edges = 0; m_load = 0;
    m_shown = '0; m_valid = 1'b0; m_ovf = 1'b0;
    m_an = 4'hF; m_seg = 7'h7F;
  endtask

  task automatic model_edge(input logic mw, input logic [15:0] w);
    int  cur;
    int  d;
    bit  expired;
    bit  do_pop;
    logic [3:0] nib;
    cur = m_edges + 1;
    // Display lines show the pre-edge word/digit/mode.
    d = (m_edges / SDIV) % 4;
    if (m_mode == 0) begin
      m_an = 4'hF; m_seg = 7'h7F;
    end else begin
      nib   = 4'(m_shown >> (4 * d));
      m_an  = ~(4'(1) << d);
      m_seg = ~HEX_TAB[nib];
    end
    expired = (m_mode == 1) && (cur - m_load == HOLD);
    do_pop  = (m_q.size() > 0) && (m_mode != 1 || expired);
    if (expired && m_q.size() == 0) m_mode = 2;
    if (do_pop) begin
      m_shown = m_q.pop_front();
      m_valid = 1'b1;
      m_load  = cur;
      m_mode  = 1;
    end
    if (mw) begin
      if (m_q.size() < DEPTH) m_q.push_back(w);
      else m_ovf = 1'b1;  // pop already applied above frees a slot first
    end
    m_edges = cur;
  endtask

  // One clock: drive inputs now, advance model at the edge, check #1 later.
  task automatic step(input logic mw, input logic [15:0] w);
    bus_if.OUT_MW     = mw;
    bus_if.OUTPUT_MSB = w[15:8];
    bus_if.OUTPUT_LSB = w[7:0];
    @(posedge main_clk);
    model_edge(mw, w);
    #1;
    check("shown_word", 32'(shown_word), 32'(m_shown));
    check("word_valid", 32'(word_valid), 32'(m_valid));
    check("fifo_full",  32'(fifo_full),  32'(m_q.size() == DEPTH));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("an_n",       32'(an_n),       32'(m_an));
    check("seg_n",      32'(seg_n),      32'(m_seg));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
  endtask

  // Reset asserted between edges; outputs must clear with no clock edge.
  task automatic mid_reset(input string tag);
    bus_if.OUT_MW = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check({tag, "_rst_shown"}, 32'(shown_word), 32'h0);
    check({tag, "_rst_valid"}, 32'(word_valid), 32'h0);
    check({tag, "_rst_full"},  32'(fifo_full),  32'h0);
    check({tag, "_rst_ovf"},   32'(overflow),   32'h0);
    check({tag, "_rst_an"},    32'(an_n),       32'hF);
    check({tag, "_rst_seg"},   32'(seg_n),      32'h7F);
    model_reset();
    @(posedge main_clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bus_if.OUT_MW = 1'b0;
    bus_if.OUTPUT_MSB = '0;
    bus_if.OUTPUT_LSB = '0;
    model_reset();
    repeat (2) @(posedge main_clk);
    #1;
    rst = 1'b1;

    // Single word 0x1234: visible after the next edge, digits decode.
    step(1'b1, 16'h1234);
    step(1'b0, 16'h0000);
    check("single_shown", 32'(shown_word), 32'h1234);
    check("single_valid", 32'(word_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'h0000);
      if (an_n == 4'b1110) check("digit0_is_4", 32'(seg_n), 32'h19);
      if (an_n == 4'b0111) check("digit3_is_1", 32'(seg_n), 32'h79);
    end

    mid_reset("r1");

    // Six back-to-back writes: fifth fills the FIFO, sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'hA000 + 16'(i));
      if (i == 4) check("a_full_after_e4", 32'(fifo_full), 32'h1);
      if (i == 5) check("a_ovf_after_e5", 32'(overflow), 32'h1);
    end
    idle(5 * HOLD + 6);
    check("a_wait_shown", 32'(shown_word), 32'hA004);
    check("a_wait_lit", 32'(an_n != 4'hF), 32'h1);

    mid_reset("r2");

    // Fill the FIFO, then write exactly on the first hold-expiry edge (E9).
    for (int i = 0; i < 5; i++) step(1'b1, 16'hC000 + 16'(i));
    idle(4);
    step(1'b1, 16'hC0DE);
    check("coinc_full", 32'(fifo_full), 32'h1);
    check("coinc_ovf",  32'(overflow),  32'h0);
    idle(6 * HOLD);
    check("coinc_last", 32'(shown_word), 32'hC0DE);

    mid_reset("r3");

    // Scan rotation on 0xBEEF.
    step(1'b1, 16'hBEEF);
    idle(20);

    // Reset mid-HOLD with three words queued, then one fresh word.
    mid_reset("r4");
    for (int i = 0; i < 4; i++) step(1'b1, 16'h5550 + 16'(i));
    mid_reset("r5");
    step(1'b1, 16'h0001);
    step(1'b0, 16'h0000);
    check("post_rst_shown", 32'(shown_word), 32'h0001);
    check("post_rst_ovf",   32'(overflow),   32'h0);
    idle(12);

    // Randomized traffic at three write densities.
    for (int s = 0; s < 3; s++) begin
      int pct;
      pct = (s == 0) ? 10 : (s == 1) ? 35 : 85;
      for (int i = 0; i < 300; i++) begin
        step($urandom_range(0, 99) < pct, 16'($urandom));
      end
      if (s == 1) mid_reset("rr");
    end
    idle(6 * HOLD);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/out_port_display.md
Name: out_port_display

Overview:
- Consumer end of the CPU output-port interface (OUT_MW strobe with OUTPUT_MSB/OUTPUT_MSB-LSB word pair).
- Captures each 16-bit output word into a small FIFO.
- Shows each word on a 4-digit multiplexed 7-segment display for a guaranteed minimum time, so back-to-back CPU writes are not lost visually.
- Sits beside the CPU core at board top level.

Parameters:
- FIFO_DEPTH, 4, words buffered (power of 2, >=2)
- HOLD_CYCLES, 1000, minimum main_clk cycles each word is displayed (>=2)
- SCAN_DIV, 16, main_clk cycles per digit during scan (>=1)

Ports:
- main_clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- OUT_MW  in  1  output-write strobe; each high cycle = one word
- OUTPUT_LSB  in  8  word bits [7:0]
- OUTPUT_MSB  in  8  word bits [15:8]
- shown_word  out  16  word currently displayed
- word_valid  out  1  at least one word displayed since reset
- fifo_full  out  1  FIFO holds FIFO_DEPTH words
- overflow  out  1  sticky: a word was dropped
- an_n  out  4  digit enables, active-low, one-hot
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (rst=0, asynchronous): shown_word=0, word_valid=0, fifo_full=0, overflow=0, an_n=4'b1111, seg_n=7'h7F. FIFO emptied, scan counter and digit index cleared, FSM=IDLE. Outputs change immediately, without waiting for a clock edge.
- Push:
  - On an edge with OUT_MW=1, {OUTPUT_MSB,OUTPUT_LSB} is written if the FIFO is not full, or if a pop occurs on the same edge.
  - Otherwise the word is dropped and overflow is set. overflow stays set until reset.
- Pop: occurs only on FSM load edges, defined below. Simultaneous push+pop leaves the count unchanged.
- FSM states: IDLE, HOLD, WAIT. hold_cnt is $clog2(HOLD_CYCLES) bits.
  - IDLE: display blank. If FIFO non-empty: pop, shown_word<=head, word_valid<=1, hold_cnt<=HOLD_CYCLES-1, go to HOLD.
  - HOLD: hold_cnt decrements each cycle. When hold_cnt==0:
    - FIFO non-empty: pop/load as in IDLE and stay in HOLD.
    - FIFO empty: go to WAIT.
  - WAIT: the last word stays displayed. If FIFO non-empty: pop/load, go to HOLD.
- Timing:
  - Latency: a word pushed at edge E0 into an empty FIFO while in IDLE or WAIT is on shown_word after edge E1.
  - With a backlog, each word is shown for exactly HOLD_CYCLES cycles.
- Scan:
  - Free-running counter. The digit index advances 0→1→2→3→0 every SCAN_DIV cycles.
  - an_n[i]=0 for the active digit i.
  - Digit i shows hex nibble shown_word[4i+3:4i].
  - In IDLE, an_n=4'b1111 and seg_n=7'h7F, but the counter keeps running.
- seg_n pattern: standard hex encoding, inverted.
  - Active-high gfedcba values: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- an_n and seg_n are registered outputs (one cycle after the digit index changes).
- fifo_full is registered, consistent with the post-edge count.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE/HOLD/WAIT);
  - the 16-entry hex-to-segment constant table;
  - the blank pattern 7'h7F.
- One sub-module: out_word_fifo, a synchronous FIFO.
  - Parameters: width 16, FIFO_DEPTH.
  - Signals: push, pop, dout = head (show-ahead), full, empty, async active-low reset.

Test Plan (HOLD_CYCLES=8, SCAN_DIV=2):
- Reset: pulse rst low mid-clock → all outputs at reset values without a clock edge; an_n=1111, seg_n=7F.
- Single write MSB=0x12, LSB=0x34 at E0 → shown_word=0x1234 and word_valid=1 after E1. When an_n=1110, seg_n=7'h19 (digit "4"); when an_n=0111, seg_n=7'h79 (digit "1").
- Six back-to-back writes 0xA000..0xA005 from IDLE:
  - 0xA000 is popped at E1.
  - FIFO full after E4.
  - 0xA005 is dropped and overflow=1.
  - Display shows 0xA000..0xA004 in order, each for exactly 8 cycles, then stays in WAIT showing 0xA004.
- FIFO full, OUT_MW=1 on the hold-expiry edge (pop and push coincide) → word accepted, overflow stays 0, fifo_full stays 1.
- Scan rotation with word 0xBEEF: an_n cycles 1110,1101,1011,0111, each for 2 cycles, then wraps. seg_n is 0x0E, 0x06, 0x06, 0x03 (F, E, E, b).
- Reset asserted mid-HOLD with 3 words queued → FIFO empty, FSM IDLE, display blank. A subsequent single write 0x0001 is displayed 2 edges later, and overflow=0.
